vsync_rx: RTL and testbench

- Receive-side counterpart of the vertical timing generator.
- Observes the line-rate hsync and frame-rate vsync pulses and verifies frame length against the expected line total.
- Runs a lock state machine and regenerates a phase-aligned line count, vblank and 4V strobe.
- Feeds downstream sprite/score logic and a "video OK" indicator; also serves as a self-check monitor on the timing chain.

---
 rtl/vsync_rx.sv | 120 ++++++++++++
 tb/tb_vsync_rx.sv | 122 ++++++++++++
 2 files changed

// File: rtl/vsync_rx.sv
// vsync_rx: frame-length checker and lock FSM regenerating line count, vblank and 4V from hsync/vsync
module vsync_rx #(
  parameter int LINES         = 262,
  parameter int VS_LINE       = 4,
  parameter int VBL_LINES     = 16,
  parameter int LOCK_FRAMES   = 3,
  parameter int UNLOCK_MISSES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [8:0] vcnt,
  output logic       vblank_out,
  output logic       v4,
  output logic       locked,
  output logic       frame_start,
  output logic       frame_err
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int MW = $clog2(UNLOCK_MISSES + 1);
  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;
  state_t state_q, state_d;
  logic hsync_q, vsync_q, hs_rise, vs_rise, timeout, good;
  logic [8:0] frame_len_q, frame_len_d, vcnt_q, vcnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_d, good_inc;
  logic [MW-1:0] miss_cnt_q, miss_cnt_d, miss_inc;
  logic vblank_q, v4_q, locked_q, frame_start_q, frame_err_q, frame_start_d, frame_err_d;
  assign hs_rise  = hsync_in & ~hsync_q;
  assign vs_rise  = vsync_in & ~vsync_q;
  // timeout fires only on the step 510 -> 511; the counter then sticks so it cannot refire
  assign timeout  = hs_rise & ~vs_rise & (frame_len_q == 9'd510);
  assign good     = frame_len_q == 9'(LINES);
  assign good_inc = good_cnt_q + 1'b1;
  assign miss_inc = miss_cnt_q + 1'b1;
  assign vcnt        = vcnt_q;
  assign vblank_out  = vblank_q;
  assign v4          = v4_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign frame_err   = frame_err_q;
  // frame length counter and recovered line counter
  always_comb begin
    frame_len_d = vs_rise ? {8'd0, hs_rise}
                : (hs_rise && frame_len_q != 9'd511) ? frame_len_q + 9'd1 : frame_len_q;
    vcnt_d      = vs_rise ? 9'(VS_LINE) + {8'd0, hs_rise}
                : hs_rise ? ((vcnt_q == 9'(LINES - 1)) ? 9'd0 : vcnt_q + 9'd1) : vcnt_q;
  end
  // lock FSM next state; judged only on vsync edges and on timeout
  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    frame_start_d = 1'b0;
    frame_err_d   = 1'b0;
    case (state_q)
      HUNT: if (vs_rise) begin
        state_d    = CHECK;
        good_cnt_d = '0;
      end
      CHECK: if (vs_rise && good) begin
        good_cnt_d = good_inc;
        if (good_inc == GW'(LOCK_FRAMES)) begin
          state_d       = LOCKED;
          miss_cnt_d    = '0;
          frame_start_d = 1'b1;
        end
      end else if (vs_rise) begin
        good_cnt_d  = '0;
        frame_err_d = 1'b1;
      end else if (timeout) begin
        frame_err_d = 1'b1;
        state_d     = HUNT;
      end
      LOCKED: if (vs_rise && good) begin
        miss_cnt_d    = '0;
        frame_start_d = 1'b1;
      end else if (vs_rise) begin
        frame_err_d = 1'b1;
        miss_cnt_d  = miss_inc;
        if (miss_inc == MW'(UNLOCK_MISSES)) state_d = HUNT;
        else frame_start_d = 1'b1;
      end else if (timeout) begin
        frame_err_d = 1'b1;
        state_d     = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end
  // all state and outputs registered; decoded outputs come from next-state vcnt to stay aligned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_len_q   <= '0;
      vcnt_q        <= '0;
      state_q       <= HUNT;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      vblank_q      <= 1'b1;
      v4_q          <= 1'b0;
      locked_q      <= 1'b0;
      frame_start_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      hsync_q       <= hsync_in;
      vsync_q       <= vsync_in;
      frame_len_q   <= frame_len_d;
      vcnt_q        <= vcnt_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      vblank_q      <= vcnt_d < 9'(VBL_LINES);
      v4_q          <= vcnt_d[2];
      locked_q      <= state_d == LOCKED;
      frame_start_q <= frame_start_d;
      frame_err_q   <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_vsync_rx.sv
// tb_vsync_rx: directed table-driven bench for the vsync receiver lock and phase recovery
module tb_vsync_rx;
  logic clk = 1'b0, reset = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic [8:0] vcnt;
  logic vblank_out, v4, locked, frame_start, frame_err;
  int checks = 0, fails = 0, fs_seen = 0, fe_seen = 0;
  typedef struct {int lines; logic l; logic fs; logic fe;} vec_t;
  vec_t tbl[14];
  vsync_rx dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vcnt(vcnt), .vblank_out(vblank_out), .v4(v4), .locked(locked),
    .frame_start(frame_start), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  // tally every pulse so stray ones between vsyncs are visible
  always @(negedge clk) begin
    if (frame_start) fs_seen++;
    if (frame_err) fe_seen++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic hs();
    @(negedge clk) hsync_in = 1'b1;
    @(negedge clk) hsync_in = 1'b0;
  endtask
  task automatic vs(input logic with_hs);
    @(negedge clk) begin vsync_in = 1'b1; hsync_in = with_hs; end
    @(negedge clk) begin vsync_in = 1'b0; hsync_in = 1'b0; end
  endtask
  task automatic frame(input int n, input logic el, input logic efs, input logic efe);
    int f0;
    f0 = fs_seen + fe_seen;
    repeat (n) hs();
    chk("no_stray_pulse", 32'(fs_seen + fe_seen - f0), 0);
    vs(1'b0);
    chk("vcnt_at_vs", 32'(vcnt), 4);
    chk("locked", 32'(locked), 32'(el));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("frame_err", 32'(frame_err), 32'(efe));
    @(negedge clk);
    chk("pulse_width", 32'({frame_start, frame_err}), 0);
  endtask
  initial begin
    int e, f0;
    tbl[0]  = '{10,  1'b0, 1'b0, 1'b0};
    tbl[1]  = '{262, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{262, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{262, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{262, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{261, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{262, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{263, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{263, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{262, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{100, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{262, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{262, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{262, 1'b1, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_vcnt", 32'(vcnt), 0);
    chk("rst_vblank", 32'(vblank_out), 1);
    chk("rst_v4", 32'(v4), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pulses", 32'({frame_start, frame_err}), 0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 14; i++) frame(tbl[i].lines, tbl[i].l, tbl[i].fs, tbl[i].fe);
    e = 4;
    chk("phase_start", 32'({vcnt, vblank_out, v4}), 32'({9'd4, 1'b1, 1'b1}));
    for (int i = 0; i < 262; i++) begin
      hs();
      e = (e == 261) ? 0 : e + 1;
      chk("phase", 32'({vcnt, vblank_out, v4}), 32'({e[8:0], e < 16, e[2]}));
    end
    vs(1'b0);
    chk("phase_fs", 32'({locked, frame_start, frame_err}), 32'(3'b110));
    @(negedge clk);
    repeat (262) hs();
    vs(1'b1);
    chk("coinc_vcnt", 32'(vcnt), 5);
    chk("coinc_len", 32'(dut.frame_len_q), 1);
    chk("coinc_judge", 32'({locked, frame_start, frame_err}), 32'(3'b110));
    @(negedge clk);
    repeat (261) hs();
    vs(1'b0);
    chk("coinc_next", 32'({vcnt, locked, frame_start, frame_err}), 32'({9'd4, 3'b110}));
    @(negedge clk);
    f0 = fe_seen;
    repeat (510) hs();
    chk("lost_pre", 32'({locked, frame_err}), 32'(2'b10));
    hs();
    chk("lost_timeout", 32'({locked, frame_err}), 32'(2'b01));
    repeat (5) hs();
    chk("lost_len_hold", 32'(dut.frame_len_q), 511);
    chk("lost_single_err", 32'(fe_seen - f0), 1);
    vs(1'b0);
    chk("lost_return", 32'({vcnt, locked, frame_err}), 32'({9'd4, 2'b00}));
    @(negedge clk);
    frame(262, 1'b0, 1'b0, 1'b0);
    frame(262, 1'b0, 1'b0, 1'b0);
    frame(262, 1'b1, 1'b1, 1'b0);
    repeat (96) hs();
    chk("pre_rst", 32'({vcnt, locked}), 32'({9'd100, 1'b1}));
    @(negedge clk) reset = 1'b0;
    #1;
    chk("async_rst", 32'({vcnt, vblank_out, v4, locked, frame_start, frame_err}),
        32'({9'd0, 5'b10000}));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    frame(50, 1'b0, 1'b0, 1'b0);
    frame(262, 1'b0, 1'b0, 1'b0);
    frame(262, 1'b0, 1'b0, 1'b0);
    frame(262, 1'b1, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
